// File: rtl/rip_fetch.sv
// rip_fetch: instruction-fetch stage owning the PC, feeding decode from a 1-cycle-latency
// synchronous imem, with a one-entry buffer that holds an instruction across execute stalls.
module rip_fetch #(
    parameter logic [31:0] START_ADDR = 32'h0000_0000,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        ex_stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        de_ready,
    output logic [31:0] inst_code,
    output logic [31:0] if_pc,
    output logic [31:0] de_pc
);
    logic [31:0] pc_q, pc_d, resp_pc_q, hold_inst_q, hold_pc_q, de_pc_q;
    logic        resp_valid_q, hold_valid_q;
    logic        cand_valid, issue;
    always_comb begin
        cand_valid = rst_n && (hold_valid_q || resp_valid_q);
        de_ready   = cand_valid && !ex_stall && !redirect_valid;
        inst_code  = !cand_valid ? NOP_INST : hold_valid_q ? hold_inst_q : imem_rdata;
        if_pc      = !cand_valid ? 32'h0 : hold_valid_q ? hold_pc_q : resp_pc_q;
        issue      = redirect_valid || !ex_stall || (!hold_valid_q && !resp_valid_q);
        imem_en    = issue;
        imem_addr  = redirect_valid ? {redirect_pc[31:2], 2'b00} : pc_q;
        pc_d       = imem_addr + 32'd4;
    end
    assign de_pc = de_pc_q;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q         <= START_ADDR;
            resp_valid_q <= 1'b0;
            resp_pc_q    <= 32'h0;
            hold_valid_q <= 1'b0;
            hold_inst_q  <= NOP_INST;
            hold_pc_q    <= 32'h0;
            de_pc_q      <= 32'h0;
        end else begin
            resp_valid_q <= issue;
            if (issue) begin
                pc_q      <= pc_d;
                resp_pc_q <= imem_addr;
            end
            // a redirect drops both the buffered and the in-flight instruction
            if (redirect_valid)
                hold_valid_q <= 1'b0;
            else if (ex_stall && resp_valid_q && !hold_valid_q) begin
                hold_valid_q <= 1'b1;
                hold_inst_q  <= imem_rdata;
                hold_pc_q    <= resp_pc_q;
            end else if (hold_valid_q && de_ready)
                hold_valid_q <= 1'b0;
            if (de_ready)
                de_pc_q <= if_pc;
        end
    end
    a_hold_resp_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(hold_valid_q && resp_valid_q));
endmodule

// File: tb/tb_rip_fetch.sv
// tb_rip_fetch: directed + random stimulus against a stream-level fetch model; a monitor
// pops per-cycle expectations from a scoreboard queue and compares them at the falling edge.
module tb_rip_fetch;
    localparam logic [31:0] START = 32'h0000_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        ex_stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        de_ready;
    logic [31:0] inst_code, if_pc, de_pc;
    rip_fetch #(.START_ADDR(START), .NOP_INST(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .imem_en(imem_en), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .ex_stall(ex_stall), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .de_ready(de_ready), .inst_code(inst_code),
        .if_pc(if_pc), .de_pc(de_pc)
    );
    always #5 clk = ~clk;
    function automatic logic [31:0] memf(logic [31:0] a);
        return a == 32'h0 ? 32'h0050_0093 : a == 32'h4 ? 32'h00A0_0113 : a * 32'h9E37_79B1 + 32'h1357_9BDF;
    endfunction
    always @(posedge clk) if (imem_en) imem_rdata <= memf(imem_addr);
    typedef struct {
        bit          rst, first, rdy, en;
        logic [31:0] pc, inst, depc, addr;
    } exp_t;
    exp_t        q[$];
    exp_t        m;
    int          n_chk = 0, n_fail = 0, cyc_n = 0;
    logic [31:0] exp_pc = START, fetch_pc = START, last_acc = 32'h0;
    bit          first = 1'b1;
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc_n, act, exp);
        end
    endtask
    always @(negedge clk) if (q.size() != 0) begin
        m = q.pop_front();
        chk("de_ready", 32'(de_ready), 32'(m.rdy));
        if (m.rdy || m.rst || m.first) begin
            chk("inst_code", inst_code, m.rdy ? m.inst : NOP);
            chk("if_pc", if_pc, m.rdy ? m.pc : 32'h0);
        end
        if (!m.rst) begin
            chk("de_pc", de_pc, m.depc);
            chk("imem_en", 32'(imem_en), 32'(m.en));
            if (m.en) chk("imem_addr", imem_addr, m.addr);
        end
        cyc_n++;
    end
    // drive one cycle and push what the fetch stream must look like during it
    task automatic cyc(bit r, bit s, bit rd, logic [31:0] t);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = !r;
        ex_stall = s;
        redirect_valid = rd;
        redirect_pc = t;
        e.rst = r;
        e.first = first && !r;
        e.rdy = !r && !first && !s && !rd;
        e.pc = exp_pc;
        e.inst = memf(exp_pc);
        e.depc = last_acc;
        e.en = rd || !s || first;
        e.addr = rd ? {t[31:2], 2'b00} : fetch_pc;
        q.push_back(e);
        if (r) begin
            exp_pc = START;
            fetch_pc = START;
            last_acc = 32'h0;
            first = 1'b1;
        end else begin
            if (e.rdy) begin
                last_acc = exp_pc;
                exp_pc = exp_pc + 32'd4;
            end
            if (rd) exp_pc = {t[31:2], 2'b00};
            if (e.en) fetch_pc = e.addr + 32'd4;
            first = 1'b0;
        end
    endtask
    initial begin
        bit s = 1'b0;
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0);
        repeat (3) cyc(0, 1, 0, 0);
        repeat (5) cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 32'h100);
        repeat (2) cyc(0, 0, 0, 0);
        repeat (2) cyc(0, 1, 0, 0);
        cyc(0, 1, 1, 32'h200);
        repeat (2) cyc(0, 1, 0, 0);
        repeat (2) cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 32'hFFFF_FFFC);
        repeat (3) cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 32'h103);
        repeat (2) cyc(0, 0, 0, 0);
        repeat (2) cyc(0, 1, 0, 0);
        cyc(1, 1, 0, 0);
        repeat (4) cyc(0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            s = s ? ($urandom % 3 != 0) : ($urandom % 5 == 0);
            cyc($urandom % 250 == 0, s, $urandom % 8 == 0,
                ($urandom % 6 == 0) ? 32'hFFFF_FFFC : 32'($urandom));
        end
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rip_fetch.md
Name: rip_fetch

Overview:
Instruction-fetch stage directly upstream of the decode stage. Owns the PC and drives a synchronous instruction memory with 1-cycle read latency. Presents one instruction per cycle to decode as inst_code qualified by de_ready. Holds one instruction across execute stalls and redirects on branch, jump or trap requests from execute.

Parameters:
START_ADDR, 32'h0000_0000, PC value loaded at reset; first fetch address.
NOP_INST, 32'h0000_0013, value driven on inst_code whenever no valid instruction is presented.

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
imem_en  out  1  instruction memory read enable
imem_addr  out  32  instruction memory byte address; bits [1:0] always 0
imem_rdata  in  32  read data; valid the cycle after imem_en=1
ex_stall  in  1  execute stage busy; decode must not advance
redirect_valid  in  1  execute requests PC change (taken branch, JAL/JALR, trap, MRET)
redirect_pc  in  32  redirect target
de_ready  out  1  inst_code valid and accepted by decode this cycle
inst_code  out  32  instruction to decode
if_pc  out  32  PC of inst_code (combinational, same cycle)
de_pc  out  32  PC of the instruction currently in decode's output registers

Behaviour:
- State: pc_q (next address to issue), resp_valid/resp_pc (read returning this cycle), hold_valid/hold_inst/hold_pc (1-entry stall buffer), de_pc.
- Reset (rst_n=0 at edge): pc_q=START_ADDR, resp_valid=0, hold_valid=0, hold_inst=NOP_INST, hold_pc=0, de_pc=0. Outputs while in reset and the first cycle after: de_ready=0, inst_code=NOP_INST.
- Candidate: hold_valid ? (hold_inst, hold_pc) : resp_valid ? (imem_rdata, resp_pc) : none.
- de_ready = candidate exists && !ex_stall && !redirect_valid. inst_code and if_pc = candidate when one exists, else NOP_INST and 0.
- issue = redirect_valid || !ex_stall || (!hold_valid && !resp_valid). imem_en = issue.
- imem_addr = redirect_valid ? {redirect_pc[31:2],2'b00} : pc_q.
- On issue: pc_q <= imem_addr+4, with 32-bit wrap (0xFFFF_FFFC -> 0). resp_valid <= 1 and resp_pc <= imem_addr. With no issue, pc_q is held and resp_valid <= 0.
- Stall capture: if ex_stall && resp_valid && !hold_valid && !redirect_valid, then hold_valid <= 1 and hold_inst/hold_pc <= imem_rdata/resp_pc.
- Hold release: if hold_valid && de_ready, then hold_valid <= 0. The same cycle issues pc_q, so there is no bubble.
- Invariant: hold_valid && resp_valid never both 1. Covered by an assertion.
- Redirect:
  - Has priority over ex_stall. hold_valid <= 0 and the in-flight response is discarded.
  - The target is issued in the same cycle, so de_ready=1 with the target at R+1 if not stalled. Penalty is 1 bubble.
  - redirect_pc[1:0] is ignored; misalignment is handled in execute.
- de_pc <= if_pc when de_ready; otherwise held.
- Throughput: 1 instruction/cycle when unstalled, PC sequence +4.
- Reset mid-operation: all state reinitialised at the next edge. Pending memory data is ignored. Fetch restarts at START_ADDR.

Test Plan:
- Reset release, mem[0]=0x00500093, mem[4]=0x00A00113 -> cycle 1: de_ready=1, inst_code=0x00500093, if_pc=0. Cycle 2: 0x00A00113, if_pc=4. imem_addr 0,4,8.
- ex_stall high for 3 cycles starting when PC 8 data returns -> de_ready=0, imem_en=0 after one issue. hold_pc=8 captured. On release, inst at 8 presented first, then 12, with no duplicate and no skip.
- redirect_valid=1, redirect_pc=0x100 while PC 0x20 in flight -> de_ready=0 that cycle, imem_addr=0x100. Next cycle inst_code=mem[0x100], if_pc=0x100. Data for 0x20 never presented.
- Redirect asserted with ex_stall=1 and hold_valid=1 -> hold discarded, target issued, target captured into hold. Presented after ex_stall drops.
- redirect_pc=0xFFFF_FFFC -> next issue address 0x0000_0000. redirect_pc=0x103 -> imem_addr=0x100.
- rst_n pulsed low for 1 cycle mid-stream with hold_valid=1 -> de_ready=0, hold cleared, de_pc=0. Fetch resumes at START_ADDR.
